// File: rtl/enemy_fleet_scheduler.sv
// Enemy fleet scheduler: one row of enemies sharing a bitmap, with a
// registered pixel hit test and a frame-paced march/bounce/drop controller.
module enemy_fleet_scheduler #(
  parameter int N_ENEMIES       = 4,
  parameter int OBJECT_WIDTH_X  = 11,
  parameter int OBJECT_HEIGHT_Y = 48,
  parameter int SPACING         = 40,
  parameter int INIT_X          = 100,
  parameter int INIT_Y          = 32,
  parameter int STEP            = 2,
  parameter int DROP            = 8,
  parameter int MOVE_PERIOD     = 4,
  parameter int SCREEN_WIDTH    = 640,
  parameter int FLOOR_Y         = 400
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic [10:0]          pixelX,
  input  logic [10:0]          pixelY,
  input  logic [N_ENEMIES-1:0] killReq,
  input  logic                 respawn,
  output logic [10:0]          offsetX,
  output logic [10:0]          offsetY,
  output logic                 InsideRectangle,
  output logic [((N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1)-1:0] activeEnemy,
  output logic [N_ENEMIES-1:0] alive,
  output logic                 allDead,
  output logic                 reachedFloor
);
  localparam int AW = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1;
  localparam logic [31:0] SPAN =
    32'((N_ENEMIES - 1) * SPACING + OBJECT_WIDTH_X + STEP);

  typedef enum logic [1:0] {
    S_IDLE, S_CHECK, S_MOVE, S_DROP
  } state_e;

  state_e               state_q, state_d;
  logic [10:0]          baseX_q, baseX_d;
  logic [10:0]          baseY_q, baseY_d;
  logic                 dir_q, dir_d;
  logic [N_ENEMIES-1:0] alive_q, alive_d;
  logic [15:0]          frame_q, frame_d;
  logic                 floor_q, floor_d;
  logic                 hit_q, hit_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [10:0]          offX_q, offX_d;
  logic [10:0]          offY_q, offY_d;

  // Widened copies so sprite bounds past 2047 never wrap.
  logic [31:0] bx, by, px, py, x0;
  logic        at_floor;

  assign bx = {21'd0, baseX_q};
  assign by = {21'd0, baseY_q};
  assign px = {21'd0, pixelX};
  assign py = {21'd0, pixelY};
  assign at_floor = (by + 32'(OBJECT_HEIGHT_Y)) >= 32'(FLOOR_Y);

  always_comb begin
    hit_d  = 1'b0;
    idx_d  = '0;
    offX_d = '0;
    offY_d = '0;
    x0     = '0;
    // Descending scan so the lowest index is the final winner.
    for (int i = N_ENEMIES - 1; i >= 0; i--) begin
      x0 = bx + 32'(i * SPACING);
      if (alive_q[i] && px >= x0 &&
          px < x0 + 32'(OBJECT_WIDTH_X) &&
          py >= by &&
          py < by + 32'(OBJECT_HEIGHT_Y)) begin
        hit_d  = 1'b1;
        idx_d  = AW'(i);
        offX_d = pixelX - x0[10:0];
        offY_d = pixelY - baseY_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    baseX_d = baseX_q;
    baseY_d = baseY_q;
    dir_d   = dir_q;
    frame_d = frame_q;
    alive_d = alive_q & ~killReq;
    floor_d = floor_q | at_floor;
    unique case (state_q)
      S_IDLE: begin
        if (startOfFrame && !floor_q && !allDead) begin
          if (frame_q == 16'(MOVE_PERIOD - 1)) begin
            frame_d = '0;
            state_d = S_CHECK;
          end else begin
            frame_d = frame_q + 16'd1;
          end
        end
      end
      S_CHECK: begin
        if (!dir_q) begin
          state_d = (bx + SPAN > 32'(SCREEN_WIDTH)) ? S_DROP : S_MOVE;
        end else begin
          state_d = (bx < 32'(STEP)) ? S_DROP : S_MOVE;
        end
      end
      S_MOVE: begin
        baseX_d = dir_q ? baseX_q - 11'(STEP) : baseX_q + 11'(STEP);
        state_d = S_IDLE;
      end
      S_DROP: begin
        baseY_d = baseY_q + 11'(DROP);
        dir_d   = ~dir_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (respawn) begin
      state_d = S_IDLE;
      baseX_d = 11'(INIT_X);
      baseY_d = 11'(INIT_Y);
      dir_d   = 1'b0;
      frame_d = '0;
      alive_d = '1;
      floor_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baseX_q <= 11'(INIT_X);
      baseY_q <= 11'(INIT_Y);
      dir_q   <= 1'b0;
      frame_q <= '0;
      alive_q <= '1;
      floor_q <= 1'b0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      offX_q  <= '0;
      offY_q  <= '0;
    end else begin
      state_q <= state_d;
      baseX_q <= baseX_d;
      baseY_q <= baseY_d;
      dir_q   <= dir_d;
      frame_q <= frame_d;
      alive_q <= alive_d;
      floor_q <= floor_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      offX_q  <= offX_d;
      offY_q  <= offY_d;
    end
  end

  assign offsetX         = offX_q;
  assign offsetY         = offY_q;
  assign InsideRectangle = hit_q;
  assign activeEnemy     = idx_q;
  assign alive           = alive_q;
  assign allDead         = ~|alive_q;
  assign reachedFloor    = floor_q;
endmodule

// File: tb/tb_enemy_fleet_scheduler.sv
// Bench for enemy_fleet_scheduler: fixed vectors, directed corner
// sequences and random traffic against a behavioural fleet model.
module tb_enemy_fleet_scheduler;
  logic        clk = 1'b0;
  logic        reset, sof, respawn;
  logic [10:0] px, py;
  logic [3:0]  kill;
  logic [10:0] ox, oy;
  logic        ins;
  logic [1:0]  ae;
  logic [3:0]  alive_o;
  logic        all_dead, floor_o;

  int checks = 0;
  int errors = 0;

  int         m_bx, m_by, m_dir, m_cnt;
  logic [3:0] m_alive;
  logic       m_floor;

  typedef struct {
    int x; int y; int h; int a; int ox; int oy;
  } vec_t;
  vec_t vt[10];

  always #5 clk = ~clk;

  enemy_fleet_scheduler dut (
    .clk(clk),
    .reset(reset),
    .startOfFrame(sof),
    .pixelX(px),
    .pixelY(py),
    .killReq(kill),
    .respawn(respawn),
    .offsetX(ox),
    .offsetY(oy),
    .InsideRectangle(ins),
    .activeEnemy(ae),
    .alive(alive_o),
    .allDead(all_dead),
    .reachedFloor(floor_o)
  );

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_bx = 100; m_by = 32; m_dir = 0; m_cnt = 0;
    m_alive = 4'hF; m_floor = 1'b0;
  endtask

  task automatic model_hit(input int x, input int y,
                           output int h, output int a,
                           output int eox, output int eoy);
    h = 0; a = 0; eox = 0; eoy = 0;
    for (int i = 0; i < 4; i++) begin
      if (h == 0 && m_alive[i] &&
          x >= m_bx + i * 40 && x < m_bx + i * 40 + 11 &&
          y >= m_by && y < m_by + 48) begin
        h = 1; a = i;
        eox = x - (m_bx + i * 40);
        eoy = y - m_by;
      end
    end
  endtask

  task automatic do_move();
    int edge_hit;
    if (m_dir == 0) edge_hit = (m_bx + 3 * 40 + 11 + 2 > 640);
    else            edge_hit = (m_bx < 2);
    if (edge_hit != 0) begin
      m_by += 8;
      m_dir = 1 - m_dir;
    end else begin
      m_bx += (m_dir == 0) ? 2 : -2;
    end
    if (m_by + 48 >= 400) m_floor = 1'b1;
  endtask

  task automatic status(input string tag);
    check({tag, ".alive"}, int'(alive_o), int'(m_alive));
    check({tag, ".allDead"}, int'(all_dead), int'(m_alive == 0));
    check({tag, ".floor"}, int'(floor_o), int'(m_floor));
  endtask

  task automatic probe(input int x, input int y, input string tag);
    int h, a, eox, eoy;
    px = 11'(x);
    py = 11'(y);
    model_hit(x, y, h, a, eox, eoy);
    tick();
    check({tag, ".in"}, int'(ins), h);
    check({tag, ".ae"}, int'(ae), a);
    check({tag, ".ox"}, int'(ox), eox);
    check({tag, ".oy"}, int'(oy), eoy);
  endtask

  task automatic frame();
    sof = 1'b1;
    tick();
    sof = 1'b0;
    if (!m_floor && m_alive != 0) begin
      m_cnt++;
      if (m_cnt == 4) begin
        m_cnt = 0;
        do_move();
      end
    end
    repeat (4) tick();
  endtask

  task automatic do_kill(input logic [3:0] mask);
    kill = mask;
    tick();
    kill = '0;
    m_alive &= ~mask;
  endtask

  task automatic do_respawn(input logic [3:0] mask);
    respawn = 1'b1;
    kill = mask;
    tick();
    respawn = 1'b0;
    kill = '0;
    model_reset();
  endtask

  initial begin
    int guard;
    int r, x, y;
    vt[0] = '{145, 40, 1, 1, 5, 8};
    vt[1] = '{111, 32, 0, 0, 0, 0};
    vt[2] = '{110, 79, 1, 0, 10, 47};
    vt[3] = '{100, 32, 1, 0, 0, 0};
    vt[4] = '{99, 32, 0, 0, 0, 0};
    vt[5] = '{100, 80, 0, 0, 0, 0};
    vt[6] = '{230, 50, 1, 3, 10, 18};
    vt[7] = '{231, 50, 0, 0, 0, 0};
    vt[8] = '{185, 31, 0, 0, 0, 0};
    vt[9] = '{185, 32, 1, 2, 5, 0};

    reset = 1'b1; sof = 1'b0; respawn = 1'b0; kill = '0;
    px = 11'd145; py = 11'd40;
    model_reset();
    tick(); tick();
    check("rst.in", int'(ins), 0);
    check("rst.ae", int'(ae), 0);
    check("rst.ox", int'(ox), 0);
    check("rst.oy", int'(oy), 0);
    status("rst");
    reset = 1'b0;

    foreach (vt[i]) begin
      px = 11'(vt[i].x);
      py = 11'(vt[i].y);
      tick();
      check($sformatf("vec%0d.in", i), int'(ins), vt[i].h);
      check($sformatf("vec%0d.ae", i), int'(ae), vt[i].a);
      check($sformatf("vec%0d.ox", i), int'(ox), vt[i].ox);
      check($sformatf("vec%0d.oy", i), int'(oy), vt[i].oy);
    end

    repeat (3) frame();
    probe(100, 32, "cad3");
    frame();
    probe(102, 32, "cad4a");
    probe(101, 32, "cad4b");

    repeat (3) frame();
    sof = 1'b1; tick(); sof = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    model_reset();
    repeat (3) tick();
    probe(100, 32, "midrst_a");
    probe(102, 32, "midrst_b");

    repeat (3) frame();
    sof = 1'b1; tick(); sof = 1'b0;
    do_respawn(4'b0000);
    repeat (3) tick();
    probe(100, 32, "abort");

    do_kill(4'b0100);
    status("prekill");
    do_respawn(4'b0001);
    status("resp");
    probe(100, 32, "resp");
    frame(); frame(); frame(); frame();
    probe(102, 32, "resp_dir");

    guard = 0;
    while (!(m_bx == 508 && m_dir == 0) && guard < 2000) begin
      frame();
      guard++;
    end
    check("reach508", int'(guard < 2000), 1);
    probe(508, 32, "b508");
    probe(507, 32, "b507");
    repeat (4) frame();
    probe(508, 40, "drop_a");
    probe(508, 39, "drop_b");
    probe(626, 40, "drop_c");
    repeat (4) frame();
    probe(506, 40, "left_a");
    probe(505, 40, "left_b");

    guard = 0;
    while (!(m_bx == 0 && m_dir == 1) && guard < 2000) begin
      frame();
      guard++;
    end
    check("reach0", int'(guard < 2000), 1);
    probe(0, 40, "l0");
    repeat (4) frame();
    probe(0, 48, "ldrop_a");
    probe(0, 47, "ldrop_b");
    repeat (4) frame();
    probe(2, 48, "lright");
    status("bounce");

    do_respawn(4'b0000);
    do_kill(4'b0010);
    status("kill1");
    probe(145, 40, "kill1");
    probe(100, 32, "kill1b");
    do_kill(4'b0010);
    status("kill1again");
    do_kill(4'b1111);
    status("killall");
    repeat (8) frame();
    probe(100, 32, "dead");
    status("dead");

    do_respawn(4'b0000);
    for (int it = 0; it < 800; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        frame();
      end else if (r < 90) begin
        if ($urandom_range(0, 3) == 0) begin
          x = int'($urandom_range(0, 2047));
          y = int'($urandom_range(0, 2047));
        end else begin
          x = (m_bx + int'($urandom_range(0, 150)) - 6) & 2047;
          y = (m_by + int'($urandom_range(0, 60)) - 6) & 2047;
        end
        probe(x, y, "rnd");
      end else if (r < 97) begin
        do_kill(4'(1 << $urandom_range(0, 3)));
      end else begin
        do_respawn(4'($urandom_range(0, 15)));
      end
      status("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
